// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: datapath defaults, ALU op codes,
// opcode constants and the decoder control bundle carried down the pipeline.
package cpu_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int CNT_W_DEF = 16;

  // ALU operation selects driven by the decoder
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_ADDI  = 3'b011,
    ALU_ANDI  = 3'b100,
    ALU_ORI   = 3'b101,
    ALU_SLTI  = 3'b110,
    ALU_LUI   = 3'b111
  } alu_op_e;

  // Primary opcode field values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Decoder control bundle, one bit per decoder output plus the ALU op
  typedef struct packed {
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       zero_ext;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       mem_to_reg;
    logic       branch_type;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // R-type, beq/bne and sw are the instructions that actually read rt
  function automatic logic reads_rt(input ctrl_t c);
    return c.reg_dst | c.branch | c.mem_write;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that needs the register a
// load currently in EX has not yet fetched from memory.
module hazard_detect #(
  parameter int AW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_rt,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          flush,
  output logic          hazard
);

  logic rs_match;
  logic rt_match;

  // $0 is hard-wired, so a load targeting it never creates a dependency;
  // a flush kills the ID instruction anyway, so no stall is needed then
  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt & (ex_rt == id_rt);
    hazard   = ex_valid & ex_mem_read & (ex_rt != '0) & (rs_match | rt_match) & ~flush;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: carries decoder controls and operands into EX,
// inserts a single bubble on a load-use hazard and counts those bubbles.
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             RegWrite_i,
  input  logic [2:0]       ALU_op_i,
  input  logic             ALUSrc_i,
  input  logic             RegDst_i,
  input  logic             Branch_i,
  input  logic             Zero_ext_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             Jump_i,
  input  logic             MemToReg_i,
  input  logic             Branch_type_i,
  input  logic [DW-1:0]    pc_plus4_i,
  input  logic [DW-1:0]    rs_data_i,
  input  logic [DW-1:0]    rt_data_i,
  input  logic [DW-1:0]    imm_i,
  input  logic [AW-1:0]    rs_i,
  input  logic [AW-1:0]    rt_i,
  input  logic [AW-1:0]    rd_i,
  input  logic [5:0]       funct_i,
  output logic             RegWrite_o,
  output logic [2:0]       ALU_op_o,
  output logic             ALUSrc_o,
  output logic             RegDst_o,
  output logic             Branch_o,
  output logic             Zero_ext_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             Jump_o,
  output logic             MemToReg_o,
  output logic             Branch_type_o,
  output logic [DW-1:0]    pc_plus4_o,
  output logic [DW-1:0]    rs_data_o,
  output logic [DW-1:0]    rt_data_o,
  output logic [DW-1:0]    imm_o,
  output logic [AW-1:0]    rs_o,
  output logic [AW-1:0]    rt_o,
  output logic [AW-1:0]    rd_o,
  output logic [5:0]       funct_o,
  output logic             valid_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t ctrl_in;
  ctrl_t ctrl_q;
  logic  hazard;

  assign ctrl_in = '{
    reg_write:   RegWrite_i,
    alu_op:      ALU_op_i,
    alu_src:     ALUSrc_i,
    reg_dst:     RegDst_i,
    branch:      Branch_i,
    zero_ext:    Zero_ext_i,
    mem_read:    MemRead_i,
    mem_write:   MemWrite_i,
    jump:        Jump_i,
    mem_to_reg:  MemToReg_i,
    branch_type: Branch_type_i
  };

  hazard_detect #(.AW(AW)) u_hazard (
    .ex_valid    (valid_o),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_o),
    .id_rs       (rs_i),
    .id_rt       (rt_i),
    .id_uses_rt  (reads_rt(ctrl_in)),
    .flush       (flush_i),
    .hazard      (hazard)
  );

  // Pipeline register: reset, then freeze, then bubble (flush or load-use), else capture
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q     <= '0;
      valid_o    <= 1'b0;
      pc_plus4_o <= '0;
      rs_data_o  <= '0;
      rt_data_o  <= '0;
      imm_o      <= '0;
      rs_o       <= '0;
      rt_o       <= '0;
      rd_o       <= '0;
      funct_o    <= '0;
    end else if (stall_i) begin
      ctrl_q <= ctrl_q;
    end else if (flush_i || hazard) begin
      ctrl_q     <= '0;
      valid_o    <= 1'b0;
      pc_plus4_o <= '0;
      rs_data_o  <= '0;
      rt_data_o  <= '0;
      imm_o      <= '0;
      rs_o       <= '0;
      rt_o       <= '0;
      rd_o       <= '0;
      funct_o    <= '0;
    end else begin
      ctrl_q     <= ctrl_in;
      valid_o    <= 1'b1;
      pc_plus4_o <= pc_plus4_i;
      rs_data_o  <= rs_data_i;
      rt_data_o  <= rt_data_i;
      imm_o      <= imm_i;
      rs_o       <= rs_i;
      rt_o       <= rt_i;
      rd_o       <= rd_i;
      funct_o    <= funct_i;
    end
  end

  // Saturating count of load-use bubbles; flushes and frozen cycles are not counted
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (!stall_i && hazard && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

  assign RegWrite_o    = ctrl_q.reg_write;
  assign ALU_op_o      = ctrl_q.alu_op;
  assign ALUSrc_o      = ctrl_q.alu_src;
  assign RegDst_o      = ctrl_q.reg_dst;
  assign Branch_o      = ctrl_q.branch;
  assign Zero_ext_o    = ctrl_q.zero_ext;
  assign MemRead_o     = ctrl_q.mem_read;
  assign MemWrite_o    = ctrl_q.mem_write;
  assign Jump_o        = ctrl_q.jump;
  assign MemToReg_o    = ctrl_q.mem_to_reg;
  assign Branch_type_o = ctrl_q.branch_type;

  assign hazard_o     = hazard;
  assign pc_write_o   = ~stall_i & ~hazard;
  assign ifid_write_o = ~stall_i & ~hazard;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for id_ex_pipe_reg with hand-computed expectations.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_id_ex_pipe_reg;

  localparam logic [12:0] C_NONE = 13'b0;
  // {RegWrite, ALU_op[2:0], ALUSrc, RegDst, Branch, Zero_ext, MemRead, MemWrite, Jump, MemToReg, Branch_type}
  localparam logic [12:0] C_ADDI = {1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [12:0] C_LW   = {1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [12:0] C_ADD  = {1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i;
  logic [12:0] ctrl_drv;
  logic [31:0] pc_plus4_i, rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic [5:0]  funct_i;

  logic        RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, Zero_ext_o, MemRead_o;
  logic        MemWrite_o, Jump_o, MemToReg_o, Branch_type_o;
  logic [2:0]  ALU_op_o;
  logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [5:0]  funct_o;
  logic        valid_o, pc_write_o, ifid_write_o, hazard_o;
  logic [15:0] bubble_cnt_o;

  logic        s_RegWrite_o, s_ALUSrc_o, s_RegDst_o, s_Branch_o, s_Zero_ext_o, s_MemRead_o;
  logic        s_MemWrite_o, s_Jump_o, s_MemToReg_o, s_Branch_type_o;
  logic [2:0]  s_ALU_op_o;
  logic [31:0] s_pc_plus4_o, s_rs_data_o, s_rt_data_o, s_imm_o;
  logic [4:0]  s_rs_o, s_rt_o, s_rd_o;
  logic [5:0]  s_funct_o;
  logic        s_valid_o, s_pc_write_o, s_ifid_write_o, s_hazard_o;
  logic [1:0]  s_bubble_cnt_o;

  logic [12:0] ctrl_obs;
  int          total = 0;
  int          bad   = 0;

  assign ctrl_obs = {RegWrite_o, ALU_op_o, ALUSrc_o, RegDst_o, Branch_o, Zero_ext_o,
                     MemRead_o, MemWrite_o, Jump_o, MemToReg_o, Branch_type_o};

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .RegWrite_i(ctrl_drv[12]), .ALU_op_i(ctrl_drv[11:9]), .ALUSrc_i(ctrl_drv[8]),
    .RegDst_i(ctrl_drv[7]), .Branch_i(ctrl_drv[6]), .Zero_ext_i(ctrl_drv[5]),
    .MemRead_i(ctrl_drv[4]), .MemWrite_i(ctrl_drv[3]), .Jump_i(ctrl_drv[2]),
    .MemToReg_i(ctrl_drv[1]), .Branch_type_i(ctrl_drv[0]),
    .pc_plus4_i(pc_plus4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i),
    .RegWrite_o(RegWrite_o), .ALU_op_o(ALU_op_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o),
    .Branch_o(Branch_o), .Zero_ext_o(Zero_ext_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .Jump_o(Jump_o), .MemToReg_o(MemToReg_o),
    .Branch_type_o(Branch_type_o),
    .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .funct_o(funct_o),
    .valid_o(valid_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .RegWrite_i(ctrl_drv[12]), .ALU_op_i(ctrl_drv[11:9]), .ALUSrc_i(ctrl_drv[8]),
    .RegDst_i(ctrl_drv[7]), .Branch_i(ctrl_drv[6]), .Zero_ext_i(ctrl_drv[5]),
    .MemRead_i(ctrl_drv[4]), .MemWrite_i(ctrl_drv[3]), .Jump_i(ctrl_drv[2]),
    .MemToReg_i(ctrl_drv[1]), .Branch_type_i(ctrl_drv[0]),
    .pc_plus4_i(pc_plus4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i),
    .RegWrite_o(s_RegWrite_o), .ALU_op_o(s_ALU_op_o), .ALUSrc_o(s_ALUSrc_o),
    .RegDst_o(s_RegDst_o), .Branch_o(s_Branch_o), .Zero_ext_o(s_Zero_ext_o),
    .MemRead_o(s_MemRead_o), .MemWrite_o(s_MemWrite_o), .Jump_o(s_Jump_o),
    .MemToReg_o(s_MemToReg_o), .Branch_type_o(s_Branch_type_o),
    .pc_plus4_o(s_pc_plus4_o), .rs_data_o(s_rs_data_o), .rt_data_o(s_rt_data_o),
    .imm_o(s_imm_o), .rs_o(s_rs_o), .rt_o(s_rt_o), .rd_o(s_rd_o), .funct_o(s_funct_o),
    .valid_o(s_valid_o), .pc_write_o(s_pc_write_o), .ifid_write_o(s_ifid_write_o),
    .hazard_o(s_hazard_o), .bubble_cnt_o(s_bubble_cnt_o)
  );

  // Count one comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage instruction onto the inputs
  task automatic applyStimulus(input logic [12:0] c, input logic [31:0] pc, input logic [31:0] rsd,
                               input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    ctrl_drv   = c;
    pc_plus4_i = pc;
    rs_data_i  = rsd;
    rt_data_i  = rtd;
    imm_i      = imm;
    rs_i       = rs;
    rt_i       = rt;
    rd_i       = rd;
    funct_i    = fn;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    applyStimulus(C_ADDI, 32'h44, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 6'h20);

    // reset held two cycles
    tick(); tick();
    checkOutput("rst_ctrl", 64'(ctrl_obs), 64'(C_NONE));
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_pcw", 64'(pc_write_o), 64'd1);
    checkOutput("rst_ifidw", 64'(ifid_write_o), 64'd1);
    checkOutput("rst_cnt", 64'(bubble_cnt_o), 64'd0);
    checkOutput("rst_rsdata", 64'(rs_data_o), 64'd0);

    // pass-through of an addi
    rst_i = 1'b1;
    applyStimulus(C_ADDI, 32'h4, 32'h5, 32'h77, 32'h10, 5'd1, 5'd2, 5'd0, 6'h00);
    #1 checkOutput("pt_hazard_pre", 64'(hazard_o), 64'd0);
    tick();
    checkOutput("pt_ctrl", 64'(ctrl_obs), 64'(C_ADDI));
    checkOutput("pt_rsdata", 64'(rs_data_o), 64'h5);
    checkOutput("pt_rtdata", 64'(rt_data_o), 64'h77);
    checkOutput("pt_imm", 64'(imm_o), 64'h10);
    checkOutput("pt_pc", 64'(pc_plus4_o), 64'h4);
    checkOutput("pt_rt", 64'(rt_o), 64'd2);
    checkOutput("pt_valid", 64'(valid_o), 64'd1);
    checkOutput("pt_hazard", 64'(hazard_o), 64'd0);

    // load-use: lw $8 then add using $8 as rs
    applyStimulus(C_LW, 32'h8, 32'h100, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0, 6'h00);
    tick();
    checkOutput("lu_lw_ctrl", 64'(ctrl_obs), 64'(C_LW));
    applyStimulus(C_ADD, 32'hC, 32'h11, 32'h22, 32'h0, 5'd8, 5'd9, 5'd10, 6'h20);
    #1;
    checkOutput("lu_hazard", 64'(hazard_o), 64'd1);
    checkOutput("lu_pcw", 64'(pc_write_o), 64'd0);
    checkOutput("lu_ifidw", 64'(ifid_write_o), 64'd0);
    tick();
    checkOutput("lu_bub_ctrl", 64'(ctrl_obs), 64'(C_NONE));
    checkOutput("lu_bub_valid", 64'(valid_o), 64'd0);
    checkOutput("lu_bub_rsdata", 64'(rs_data_o), 64'd0);
    checkOutput("lu_cnt", 64'(bubble_cnt_o), 64'd1);
    checkOutput("lu_hazard_after", 64'(hazard_o), 64'd0);
    checkOutput("lu_pcw_after", 64'(pc_write_o), 64'd1);
    tick();
    checkOutput("lu_add_ctrl", 64'(ctrl_obs), 64'(C_ADD));
    checkOutput("lu_add_rs", 64'(rs_o), 64'd8);
    checkOutput("lu_add_rd", 64'(rd_o), 64'd10);
    checkOutput("lu_add_valid", 64'(valid_o), 64'd1);

    // lw to $0 never stalls
    applyStimulus(C_LW, 32'h10, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 6'h00);
    tick();
    applyStimulus(C_ADD, 32'h14, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 6'h20);
    #1 checkOutput("zero_hazard", 64'(hazard_o), 64'd0);
    tick();
    // addi does not read rt, add does
    applyStimulus(C_LW, 32'h18, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 6'h00);
    tick();
    applyStimulus(C_ADDI, 32'h1C, 32'h0, 32'h0, 32'h1, 5'd1, 5'd8, 5'd0, 6'h00);
    #1 checkOutput("addi_rt_hazard", 64'(hazard_o), 64'd0);
    applyStimulus(C_ADD, 32'h1C, 32'h0, 32'h0, 32'h0, 5'd3, 5'd8, 5'd4, 6'h20);
    #1 checkOutput("add_rt_hazard", 64'(hazard_o), 64'd1);
    applyStimulus(C_ADDI, 32'h1C, 32'h0, 32'h0, 32'h1, 5'd1, 5'd8, 5'd0, 6'h00);
    tick();
    checkOutput("addi_captured", 64'(ctrl_obs), 64'(C_ADDI));
    checkOutput("cnt_still1", 64'(bubble_cnt_o), 64'd1);

    // flush with a pending hazard
    applyStimulus(C_LW, 32'h20, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 6'h00);
    tick();
    applyStimulus(C_ADD, 32'h24, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9, 5'd4, 6'h20);
    flush_i = 1'b1;
    #1;
    checkOutput("fl_hazard", 64'(hazard_o), 64'd0);
    checkOutput("fl_pcw", 64'(pc_write_o), 64'd1);
    tick();
    flush_i = 1'b0;
    checkOutput("fl_ctrl", 64'(ctrl_obs), 64'(C_NONE));
    checkOutput("fl_valid", 64'(valid_o), 64'd0);
    checkOutput("fl_cnt", 64'(bubble_cnt_o), 64'd1);

    // stall freezes everything, including the counter, even with a hazard present
    applyStimulus(C_LW, 32'h28, 32'hAA, 32'hBB, 32'h8, 5'd2, 5'd8, 5'd0, 6'h00);
    tick();
    applyStimulus(C_ADD, 32'h2C, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9, 5'd4, 6'h20);
    stall_i = 1'b1;
    #1;
    checkOutput("st_hazard", 64'(hazard_o), 64'd1);
    checkOutput("st_pcw", 64'(pc_write_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(C_ADDI, 32'h100 + 32'(i), 32'h1, 32'h2, 32'h3, 5'd8, 5'd9, 5'd7, 6'h01);
      if (i == 1) flush_i = 1'b1;
      tick();
    end
    checkOutput("st_ctrl", 64'(ctrl_obs), 64'(C_LW));
    checkOutput("st_pc", 64'(pc_plus4_o), 64'h28);
    checkOutput("st_rsdata", 64'(rs_data_o), 64'hAA);
    checkOutput("st_valid", 64'(valid_o), 64'd1);
    checkOutput("st_cnt", 64'(bubble_cnt_o), 64'd1);
    checkOutput("st_cnt_sat", 64'(s_bubble_cnt_o), 64'd1);
    flush_i = 1'b0;
    stall_i = 1'b0;
    applyStimulus(C_ADD, 32'h2C, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9, 5'd4, 6'h20);
    tick();
    checkOutput("st_release_bub", 64'(valid_o), 64'd0);
    checkOutput("st_release_cnt", 64'(bubble_cnt_o), 64'd2);

    // drive more load-use bubbles to saturate the 2-bit counter
    for (int i = 0; i < 3; i++) begin
      applyStimulus(C_LW, 32'h40, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 6'h00);
      tick();
      applyStimulus(C_ADD, 32'h44, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9, 5'd4, 6'h20);
      tick();
    end
    checkOutput("sat_cnt_main", 64'(bubble_cnt_o), 64'd5);
    checkOutput("sat_cnt_small", 64'(s_bubble_cnt_o), 64'd3);
    checkOutput("sat_hazard_small", 64'(s_hazard_o), 64'd0);
    applyStimulus(C_LW, 32'h48, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 6'h00);
    tick();
    applyStimulus(C_ADD, 32'h4C, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9, 5'd4, 6'h20);
    #1 checkOutput("sat_hazard_on", 64'(s_hazard_o), 64'd1);
    tick();
    checkOutput("sat_cnt_main2", 64'(bubble_cnt_o), 64'd6);
    checkOutput("sat_cnt_held", 64'(s_bubble_cnt_o), 64'd3);

    // reset during a pending hazard empties the pipe and clears the counter
    applyStimulus(C_LW, 32'h50, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 6'h00);
    tick();
    applyStimulus(C_ADD, 32'h54, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9, 5'd4, 6'h20);
    #1 checkOutput("rh_hazard", 64'(hazard_o), 64'd1);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    checkOutput("rh_valid", 64'(valid_o), 64'd0);
    checkOutput("rh_ctrl", 64'(ctrl_obs), 64'(C_NONE));
    checkOutput("rh_cnt", 64'(bubble_cnt_o), 64'd0);
    checkOutput("rh_pcw", 64'(pc_write_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
